// File: rtl/alu_cmd_sequencer.sv
// Command-frame sequencer between the UART byte interfaces and the ALU datapath.
// Parses CC/DD frames, strobes the datapath once, then returns the 16-bit result LSB-first.
`timescale 1ns/1ps
module alu_cmd_sequencer #(
  parameter int OP_WIDTH   = 8,
  parameter int RES_WIDTH  = 16,
  parameter int FUNC_WIDTH = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [OP_WIDTH-1:0]   alu_a,
  output logic [OP_WIDTH-1:0]   alu_b,
  output logic [FUNC_WIDTH-1:0] alu_func,
  output logic                  alu_en,
  input  logic [RES_WIDTH-1:0]  alu_out,
  input  logic                  alu_out_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_busy,
  output logic                  busy,
  output logic                  frame_err,
  output logic                  rx_drop
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_GET_A    = 4'd1,
    S_GET_B    = 4'd2,
    S_GET_FUNC = 4'd3,
    S_EXEC     = 4'd4,
    S_WAIT_RES = 4'd5,
    S_SEND_LO  = 4'd6,
    S_GAP      = 4'd7,
    S_SEND_HI  = 4'd8
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [RES_WIDTH-1:0]  res_q, res_d;
  logic [OP_WIDTH-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [FUNC_WIDTH-1:0] alu_func_q, alu_func_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  alu_en_q, alu_en_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  busy_q, busy_d;
  logic                  frame_err_q, frame_err_d;
  logic                  rx_drop_q, rx_drop_d;
  logic                  timed_out_s;
  logic                  counting_s;

  assign timed_out_s = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Next-state, datapath latches and registered-output next values
  always_comb begin
    state_d     = state_q;
    res_d       = res_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_func_d  = alu_func_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    rx_drop_d   = 1'b0;
    counting_s  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_valid && (rx_data == 8'hCC)) begin
          state_d = S_GET_A;
        end else if (rx_valid && (rx_data == 8'hDD)) begin
          state_d = S_GET_FUNC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GET_A: begin
        counting_s = 1'b1;
        if (rx_valid) begin
          alu_a_d = rx_data[OP_WIDTH-1:0];
          state_d = S_GET_B;
        end else if (timed_out_s) begin
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          state_d = S_GET_A;
        end
      end
      S_GET_B: begin
        counting_s = 1'b1;
        if (rx_valid) begin
          alu_b_d = rx_data[OP_WIDTH-1:0];
          state_d = S_GET_FUNC;
        end else if (timed_out_s) begin
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          state_d = S_GET_B;
        end
      end
      S_GET_FUNC: begin
        counting_s = 1'b1;
        if (rx_valid) begin
          alu_func_d = rx_data[FUNC_WIDTH-1:0];
          state_d    = S_EXEC;
        end else if (timed_out_s) begin
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          state_d = S_GET_FUNC;
        end
      end
      S_EXEC: begin
        rx_drop_d = rx_valid;
        state_d   = S_WAIT_RES;
      end
      S_WAIT_RES: begin
        counting_s = 1'b1;
        rx_drop_d  = rx_valid;
        if (alu_out_valid) begin
          res_d   = alu_out;
          state_d = S_SEND_LO;
        end else if (timed_out_s) begin
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          state_d = S_WAIT_RES;
        end
      end
      S_SEND_LO: begin
        rx_drop_d = rx_valid;
        if (!tx_busy) begin
          tx_data_d  = res_q[7:0];
          tx_valid_d = 1'b1;
          state_d    = S_GAP;
        end else begin
          state_d = S_SEND_LO;
        end
      end
      // tx_busy only rises the cycle after tx_valid, so SEND_HI must not look at it earlier
      S_GAP: begin
        rx_drop_d = rx_valid;
        state_d   = S_SEND_HI;
      end
      S_SEND_HI: begin
        rx_drop_d = rx_valid;
        if (!tx_busy) begin
          tx_data_d  = res_q[RES_WIDTH-1:8];
          tx_valid_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          state_d = S_SEND_HI;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if ((state_d == state_q) && counting_s) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end

    alu_en_d = (state_d == S_EXEC);
    busy_d   = (state_d != S_IDLE);
  end

  // State, counter, latches and registered outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      res_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_func_q  <= '0;
      tx_data_q   <= 8'h00;
      alu_en_q    <= 1'b0;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      rx_drop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_func_q  <= alu_func_d;
      tx_data_q   <= tx_data_d;
      alu_en_q    <= alu_en_d;
      tx_valid_q  <= tx_valid_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      rx_drop_q   <= rx_drop_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_func  = alu_func_q;
  assign alu_en    = alu_en_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
  assign rx_drop   = rx_drop_q;

endmodule
